pc_target_unit: RTL and testbench

PC_TARGET_UNIT -- requirements
Module: pc_target_unit

---
 rtl/pc_target_unit_pkg.sv | 28 ++
 rtl/pc_target_unit_calc.sv | 47 ++++
 rtl/pc_target_unit.sv | 115 +++++++++++
 tb/tb_pc_target_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_target_unit_pkg.sv
// Shared definitions for the fetch PC target unit: redirect select codes,
// FSM state encoding and instruction-alignment helpers.
package pc_target_unit_pkg;

  typedef enum logic [1:0] {
    SEL_BRANCH = 2'd0,
    SEL_JALR   = 2'd1,
    SEL_TRAP   = 2'd2,
    SEL_RSVD   = 2'd3
  } redirect_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Only 2-byte (compressed) and 4-byte alignment are meaningful.
  function automatic bit ialign_legal(input int ialign);
    return (ialign == 32'sd2) || (ialign == 32'sd4);
  endfunction

  // Number of low address bits that must be zero for a legal alignment.
  function automatic int ialign_bits(input int ialign);
    return (ialign == 32'sd2) ? 32'sd1 : 32'sd2;
  endfunction

endpackage

// File: rtl/pc_target_unit_calc.sv
// Combinational redirect target selection, address arithmetic, alignment
// masking and misalignment detection.
module pc_target_calc
  import pc_target_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};
  localparam logic [XLEN-1:0] BIT0     = {{(XLEN-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] branch_sum;
  logic [XLEN-1:0] jalr_sum;

  // Pick the target for the requested redirect kind; reserved select acts as branch.
  always_comb begin
    branch_sum = ex_pc + imm;
    jalr_sum   = (rs1 + imm) & ~BIT0;
    target     = branch_sum;
    misaligned = 1'b0;
    case (sel)
      SEL_JALR: begin
        target     = jalr_sum;
        misaligned = |(jalr_sum & LOW_MASK);
      end
      SEL_TRAP: begin
        // Trap vectors are forced onto an aligned address, so they never fault.
        target     = trap_vec & ~LOW_MASK;
        misaligned = 1'b0;
      end
      default: begin
        target     = branch_sum;
        misaligned = |(branch_sum & LOW_MASK);
      end
    endcase
  end

endmodule

// File: rtl/pc_target_unit.sv
// Fetch PC generator: holds the fetch PC, advances it on fetch handshake,
// applies redirects and parks in FAULT after a misaligned redirect until a
// trap redirect arrives.
module pc_target_unit
  import pc_target_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              IALIGN   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [1:0]      redirect_sel_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic            fetch_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  // An illegal IALIGN falls back to 4-byte alignment.
  localparam int ALIGN_BITS = ialign_legal(IALIGN) ? ialign_bits(IALIGN) : 32'sd2;
  localparam int STEP       = ialign_legal(IALIGN) ? IALIGN : 32'sd4;

  state_e          state;
  state_e          state_next;
  logic [XLEN-1:0] pc_next;
  logic            misalign_next;
  logic [XLEN-1:0] misalign_addr_next;
  logic [XLEN-1:0] target;
  logic            target_misaligned;

  pc_target_calc #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_calc (
    .sel        (redirect_sel_i),
    .ex_pc      (ex_pc_i),
    .imm        (imm_i),
    .rs1        (rs1_i),
    .trap_vec   (trap_vec_i),
    .target     (target),
    .misaligned (target_misaligned)
  );

  assign pc_inc_o = pc_o + XLEN'(STEP);

  // Next-state and next-PC selection: redirect beats stall beats handshake advance.
  always_comb begin
    state_next         = state;
    pc_next            = pc_o;
    misalign_next      = 1'b0;
    misalign_addr_next = misalign_addr_o;
    case (state)
      ST_IDLE: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid_i) begin
          if (target_misaligned) begin
            misalign_next      = 1'b1;
            misalign_addr_next = target;
            state_next         = ST_FAULT;
          end else begin
            pc_next = target;
          end
        end else if (stall_i) begin
          pc_next = pc_o;
        end else if (fetch_ready_i) begin
          pc_next = pc_inc_o;
        end else begin
          pc_next = pc_o;
        end
      end
      ST_FAULT: begin
        // Only a trap redirect gets us out; everything else is dropped.
        if (redirect_valid_i && (redirect_sel_i == SEL_TRAP)) begin
          pc_next    = target;
          state_next = ST_RUN;
        end else begin
          state_next = ST_FAULT;
        end
      end
      default: begin
        state_next = ST_IDLE;
        pc_next    = RESET_PC;
      end
    endcase
  end

  // State, PC and status registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      pc_o            <= RESET_PC;
      fetch_valid_o   <= 1'b0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= {XLEN{1'b0}};
    end else begin
      state           <= state_next;
      pc_o            <= pc_next;
      fetch_valid_o   <= (state_next == ST_RUN);
      misalign_o      <= misalign_next;
      misalign_addr_o <= misalign_addr_next;
    end
  end

endmodule

// File: tb/tb_pc_target_unit.sv
// Self-checking bench for pc_target_unit: one instance with IALIGN=4 and one
// with IALIGN=2 share stimulus. Directed vector table, async reset in FAULT,
// then randomized stimulus against a behavioural model.
module tb_pc_target_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        rv;
  logic [1:0]  sel;
  logic [31:0] ex_pc, imm, rs1, trap_vec;
  logic        ready;

  logic [31:0] pc4, inc4, addr4, pc2, inc2, addr2;
  logic        fv4, mis4, fv2, mis2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_target_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .IALIGN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_sel_i(sel), .ex_pc_i(ex_pc), .imm_i(imm), .rs1_i(rs1),
    .trap_vec_i(trap_vec), .fetch_ready_i(ready), .pc_o(pc4), .pc_inc_o(inc4),
    .fetch_valid_o(fv4), .misalign_o(mis4), .misalign_addr_o(addr4));

  pc_target_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .IALIGN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_sel_i(sel), .ex_pc_i(ex_pc), .imm_i(imm), .rs1_i(rs1),
    .trap_vec_i(trap_vec), .fetch_ready_i(ready), .pc_o(pc2), .pc_inc_o(inc2),
    .fetch_valid_o(fv2), .misalign_o(mis2), .misalign_addr_o(addr2));

  // Behavioural model, index 0 = IALIGN 4, index 1 = IALIGN 2.
  bit          m_started[2];
  bit          m_faulted[2];
  logic [31:0] m_pc[2];
  logic [31:0] m_addr[2];
  bit          m_mis[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void calc_target(input int unsigned align, output logic [31:0] t, output bit bad);
    logic [31:0] s;
    case (sel)
      2'd1: begin
        s   = rs1 + imm;
        t   = (s / 32'd2) * 32'd2;
        bad = (t % align) != 32'd0;
      end
      2'd2: begin
        t   = trap_vec - (trap_vec % align);
        bad = 1'b0;
      end
      default: begin
        t   = ex_pc + imm;
        bad = (t % align) != 32'd0;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 1'b0;
      m_faulted[k] = 1'b0;
      m_pc[k]      = 32'h0;
      m_addr[k]    = 32'h0;
      m_mis[k]     = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int unsigned align;
      logic [31:0] t;
      bit          bad;
      align    = (k == 0) ? 32'd4 : 32'd2;
      calc_target(align, t, bad);
      m_mis[k] = 1'b0;
      if (!m_started[k]) begin
        m_started[k] = 1'b1;
      end else if (m_faulted[k]) begin
        if (rv && sel == 2'd2) begin
          m_pc[k]      = t;
          m_faulted[k] = 1'b0;
        end
      end else if (rv) begin
        if (bad) begin
          m_mis[k]     = 1'b1;
          m_addr[k]    = t;
          m_faulted[k] = 1'b1;
        end else begin
          m_pc[k] = t;
        end
      end else if (!stall && ready) begin
        m_pc[k] = m_pc[k] + align;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic compare_model();
    check("rnd_pc4",   pc4,   m_pc[0]);
    check("rnd_inc4",  inc4,  m_pc[0] + 32'd4);
    check("rnd_fv4",   {31'd0, fv4},  {31'd0, m_started[0] && !m_faulted[0]});
    check("rnd_mis4",  {31'd0, mis4}, {31'd0, m_mis[0]});
    check("rnd_addr4", addr4, m_addr[0]);
    check("rnd_pc2",   pc2,   m_pc[1]);
    check("rnd_inc2",  inc2,  m_pc[1] + 32'd2);
    check("rnd_fv2",   {31'd0, fv2},  {31'd0, m_started[1] && !m_faulted[1]});
    check("rnd_mis2",  {31'd0, mis2}, {31'd0, m_mis[1]});
    check("rnd_addr2", addr2, m_addr[1]);
  endtask

  typedef struct {
    logic        stall, rv, ready;
    logic [1:0]  sel;
    logic [31:0] ex_pc, imm, rs1, trap_vec;
    logic [31:0] e_pc4;
    logic        e_fv4, e_mis4;
    logic [31:0] e_addr4;
    logic [31:0] e_pc2;
    logic        e_fv2;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // stall rv rdy sel ex_pc imm rs1 trap | pc4 fv4 mis4 addr4 | pc2 fv2
    vecs[0]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h0,1'b1,1'b0,32'h0,        32'h0,1'b1};
    vecs[1]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h4,1'b1,1'b0,32'h0,        32'h2,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h8,1'b1,1'b0,32'h0,        32'h4,1'b1};
    vecs[3]  = '{1'b1,1'b1,1'b1,2'd0,32'h100,32'hFFFF_FFF0,32'h0,32'h0,       32'hF0,1'b1,1'b0,32'h0,       32'hF0,1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b1,2'd1,32'h0,32'h0,32'h203,32'h0,               32'hF0,1'b0,1'b1,32'h202,     32'h202,1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b1,2'd0,32'h400,32'h0,32'h0,32'h0,               32'hF0,1'b0,1'b0,32'h202,     32'h400,1'b1};
    vecs[6]  = '{1'b0,1'b1,1'b1,2'd2,32'h0,32'h0,32'h0,32'h8000_0003,         32'h8000_0000,1'b1,1'b0,32'h202, 32'h8000_0002,1'b1};
    vecs[7]  = '{1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h8000_0000,1'b1,1'b0,32'h202, 32'h8000_0002,1'b1};
    vecs[8]  = '{1'b1,1'b0,1'b1,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h8000_0000,1'b1,1'b0,32'h202, 32'h8000_0002,1'b1};
    vecs[9]  = '{1'b0,1'b1,1'b1,2'd3,32'h10,32'h8,32'h0,32'h0,                32'h18,1'b1,1'b0,32'h202,     32'h18,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b0,2'd0,32'hFFFF_FFF8,32'h4,32'h0,32'h0,         32'hFFFF_FFFC,1'b1,1'b0,32'h202, 32'hFFFF_FFFC,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b1,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h0,1'b1,1'b0,32'h202,      32'hFFFF_FFFE,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0,32'h0,                 32'h0,1'b1,1'b0,32'h202,      32'hFFFF_FFFE,1'b1};
    vecs[13] = '{1'b0,1'b1,1'b1,2'd0,32'h0,32'h6,32'h0,32'h0,                 32'h0,1'b0,1'b1,32'h6,        32'h6,1'b1};

    rst_n = 1'b0; stall = 1'b0; rv = 1'b0; sel = 2'd0; ready = 1'b1;
    ex_pc = 32'h0; imm = 32'h0; rs1 = 32'h0; trap_vec = 32'h0;
    model_reset();
    #12;
    check("reset_pc4",   pc4,   32'h0);
    check("reset_fv4",   {31'd0, fv4},  32'd0);
    check("reset_mis4",  {31'd0, mis4}, 32'd0);
    check("reset_addr4", addr4, 32'h0);
    check("reset_fv2",   {31'd0, fv2},  32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_fv4", {31'd0, fv4}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      stall = vecs[i].stall; rv = vecs[i].rv; ready = vecs[i].ready; sel = vecs[i].sel;
      ex_pc = vecs[i].ex_pc; imm = vecs[i].imm; rs1 = vecs[i].rs1; trap_vec = vecs[i].trap_vec;
      tick();
      check($sformatf("vec%0d_pc4", i),   pc4,   vecs[i].e_pc4);
      check($sformatf("vec%0d_inc4", i),  inc4,  vecs[i].e_pc4 + 32'd4);
      check($sformatf("vec%0d_fv4", i),   {31'd0, fv4},  {31'd0, vecs[i].e_fv4});
      check($sformatf("vec%0d_mis4", i),  {31'd0, mis4}, {31'd0, vecs[i].e_mis4});
      check($sformatf("vec%0d_addr4", i), addr4, vecs[i].e_addr4);
      check($sformatf("vec%0d_pc2", i),   pc2,   vecs[i].e_pc2);
      check($sformatf("vec%0d_fv2", i),   {31'd0, fv2},  {31'd0, vecs[i].e_fv2});
      check($sformatf("vec%0d_mis2", i),  {31'd0, mis2}, 32'd0);
    end

    // misalign pulse must drop the cycle after it fires, still in FAULT.
    rv = 1'b0; stall = 1'b0; ready = 1'b1;
    tick();
    check("pulse_once_mis4", {31'd0, mis4}, 32'd0);
    check("fault_hold_fv4",  {31'd0, fv4},  32'd0);
    check("fault_hold_pc4",  pc4,   32'h0);
    check("fault_addr_hold", addr4, 32'h6);

    // Async reset asserted mid-cycle while in FAULT.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_fault_pc4",   pc4,   32'h0);
    check("rst_fault_fv4",   {31'd0, fv4},  32'd0);
    check("rst_fault_mis4",  {31'd0, mis4}, 32'd0);
    check("rst_fault_addr4", addr4, 32'h0);
    check("rst_fault_pc2",   pc2,   32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Randomized stimulus against the model.
    for (int n = 0; n < 600; n++) begin
      rv       = ($urandom % 4) == 0;
      sel      = 2'($urandom % 4);
      stall    = ($urandom % 4) == 0;
      ready    = ($urandom % 4) != 0;
      ex_pc    = $urandom;
      imm      = 32'($urandom_range(0, 63)) - 32'd32;
      rs1      = $urandom;
      trap_vec = $urandom;
      tick();
      compare_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
